// File: rtl/jk_bank_arbiter_if.sv
// Request/grant bus between control agents and the shared JK flip-flop bank arbiter.
// master = requesting agents, slave = the arbiter.
interface jk_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op_flat;
  logic [WIDTH*NREQ-1:0] mask_flat;
  logic [NREQ-1:0]       gnt;
  logic                  done;
  logic                  busy;
  logic [WIDTH-1:0]      q;

  modport master (
    output req, op_flat, mask_flat,
    input  gnt, done, busy, q
  );

  modport slave (
    input  req, op_flat, mask_flat,
    output gnt, done, busy, q
  );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sequencing JK operations from NREQ agents onto one WIDTH-bit flip-flop bank.
// Optional macro JKBANK_PRIO0_EN gives requester 0 fixed absolute priority.
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  jk_bank_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] mask_r_q, mask_r_d;
  logic [1:0]       op_r_q, op_r_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    win_q, win_d;

  logic             found;
  logic [IW-1:0]    win_idx;
  logic [WIDTH-1:0] j_vec, k_vec, s_vec, r_vec, bank_next;

  // Search order starts at ptr and wraps, so the last winner ends up lowest priority.
  always_comb begin
    int idx;
    idx     = 0;
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req[idx]) begin
        found   = 1'b1;
        win_idx = IW'(idx);
      end
    end
`ifdef JKBANK_PRIO0_EN
    if (bus.req[0]) begin
      found   = 1'b1;
      win_idx = '0;
    end
`else
`endif
  end

  // S and R are gated by the current bit value, so they can never both be active.
  always_comb begin
    j_vec     = {WIDTH{op_r_q[1]}} & mask_r_q;
    k_vec     = {WIDTH{op_r_q[0]}} & mask_r_q;
    s_vec     = j_vec & ~q_q;
    r_vec     = k_vec & q_q;
    bank_next = (q_q | s_vec) & ~r_vec;
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = done_q;
    q_d      = q_q;
    mask_r_d = mask_r_q;
    op_r_d   = op_r_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          op_r_d         = bus.op_flat[2*int'(win_idx) +: 2];
          mask_r_d       = bus.mask_flat[WIDTH*int'(win_idx) +: WIDTH];
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          win_d          = win_idx;
          state_d        = APPLY;
        end
      end
      APPLY: begin
        q_d     = bank_next;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b0;
        gnt_d   = '0;
        state_d = IDLE;
`ifdef JKBANK_PRIO0_EN
        if (win_q != '0) ptr_d = (win_q == IW'(NREQ-1)) ? '0 : win_q + 1'b1;
`else
        ptr_d = (win_q == IW'(NREQ-1)) ? '0 : win_q + 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      done_q   <= 1'b0;
      q_q      <= '0;
      mask_r_q <= '0;
      op_r_q   <= '0;
      ptr_q    <= '0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      q_q      <= q_d;
      mask_r_q <= mask_r_d;
      op_r_q   <= op_r_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.q    = q_q;
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter: directed operations push expected {gnt,q} at done.
// Expectations follow JKBANK_PRIO0_EN when the bench is built with that macro.
module tb_jk_bank_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  typedef struct packed {
    logic [NREQ-1:0]  gnt;
    logic [WIDTH-1:0] q;
  } exp_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  exp_t expQ[$];

  jk_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [1:0] op, input logic [WIDTH-1:0] mask);
    bus.op_flat[2*idx +: 2]          = op;
    bus.mask_flat[WIDTH*idx +: WIDTH] = mask;
    bus.req[idx]                     = 1'b1;
  endtask

  task automatic pushExp(input logic [NREQ-1:0] g, input logic [WIDTH-1:0] qv);
    exp_t e;
    e.gnt = g;
    e.q   = qv;
    expQ.push_back(e);
  endtask

  task automatic waitDone(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout actual=no_done expected=done", name);
    end
  endtask

  task automatic doOp(input int idx, input logic [1:0] op, input logic [WIDTH-1:0] mask,
                      input logic [NREQ-1:0] g, input logic [WIDTH-1:0] qv);
    @(negedge clk);
    pushExp(g, qv);
    applyStimulus(idx, op, mask);
    waitDone("op");
    bus.req[idx] = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: pops one expectation per done pulse and checks grants stay one-hot.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("gnt_onehot0", 32'($countones(bus.gnt) <= 1), 32'd1);
      if (bus.done) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_done actual=gnt:%0h q:%0h expected=no_done", bus.gnt, bus.q);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("done_gnt", 32'(bus.gnt), 32'(e.gnt));
          checkOutput("done_q", 32'(bus.q), 32'(e.q));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    rst           = 1'b0;
    bus.req       = '0;
    bus.op_flat   = '0;
    bus.mask_flat = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_q", 32'(bus.q), 32'h0);
    checkOutput("reset_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("reset_busy", 32'(bus.busy), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_q", 32'(bus.q), 32'h0);
    checkOutput("post_reset_busy", 32'(bus.busy), 32'h0);

    // Single set with cycle-by-cycle latency checks.
    pushExp(4'b0001, 8'h0F);
    applyStimulus(0, 2'b10, 8'h0F);
    @(negedge clk);
    checkOutput("lat_gnt", 32'(bus.gnt), 32'h1);
    checkOutput("lat_busy_apply", 32'(bus.busy), 32'h1);
    checkOutput("lat_q_before", 32'(bus.q), 32'h0);
    checkOutput("lat_done_early", 32'(bus.done), 32'h0);
    @(negedge clk);
    checkOutput("lat_done", 32'(bus.done), 32'h1);
    checkOutput("lat_busy_done", 32'(bus.busy), 32'h1);
    bus.req[0] = 1'b0;
    @(negedge clk);
    checkOutput("lat_gnt_clear", 32'(bus.gnt), 32'h0);
    checkOutput("lat_busy_idle", 32'(bus.busy), 32'h0);
    checkOutput("lat_done_clear", 32'(bus.done), 32'h0);

    doOp(2, 2'b11, 8'hFF, 4'b0100, 8'hF0);
    doOp(2, 2'b01, 8'h30, 4'b0100, 8'hC0);
    doOp(2, 2'b00, 8'hFF, 4'b0100, 8'hC0);

    // Asynchronous reset in the middle of APPLY.
    @(negedge clk);
    applyStimulus(1, 2'b10, 8'hFF);
    @(negedge clk);
    checkOutput("abort_gnt_before", 32'(bus.gnt), 32'h2);
    rst = 1'b0;
    #1;
    checkOutput("abort_q", 32'(bus.q), 32'h0);
    checkOutput("abort_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("abort_busy", 32'(bus.busy), 32'h0);
    checkOutput("abort_done", 32'(bus.done), 32'h0);
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("abort_q_after", 32'(bus.q), 32'h0);
    checkOutput("abort_busy_after", 32'(bus.busy), 32'h0);

    // All four requesters held continuously, each toggling its own bit.
`ifdef JKBANK_PRIO0_EN
    pushExp(4'b0001, 8'h01);
    pushExp(4'b0001, 8'h00);
    pushExp(4'b0001, 8'h01);
    pushExp(4'b0001, 8'h00);
    pushExp(4'b0001, 8'h01);
`else
    pushExp(4'b0001, 8'h01);
    pushExp(4'b0010, 8'h03);
    pushExp(4'b0100, 8'h07);
    pushExp(4'b1000, 8'h0F);
    pushExp(4'b0001, 8'h0E);
`endif
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 2'b11, WIDTH'(1 << i));
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 5; i++) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    bus.req = '0;
    checkOutput("rr_done_count", 32'(cnt), 32'd5);
    repeat (3) @(negedge clk);
    checkOutput("rr_busy_idle", 32'(bus.busy), 32'h0);

    // Requester 0 arrives while requester 1 is in APPLY.
    doReset();
    pushExp(4'b0010, 8'h02);
`ifdef JKBANK_PRIO0_EN
    pushExp(4'b0001, 8'h03);
`else
    pushExp(4'b0100, 8'h06);
`endif
    applyStimulus(1, 2'b10, 8'h02);
    applyStimulus(2, 2'b10, 8'h04);
    applyStimulus(3, 2'b10, 8'h08);
    @(negedge clk);
    checkOutput("prio_first_gnt", 32'(bus.gnt), 32'h2);
    applyStimulus(0, 2'b10, 8'h01);
    waitDone("prio_first");
    bus.req[1] = 1'b0;
    waitDone("prio_second");
    bus.req = '0;
    repeat (3) @(negedge clk);

    // Op/mask changed after grant and req dropped in DONE: latched values apply, no re-grant.
    doReset();
    pushExp(4'b1000, 8'hF0);
    applyStimulus(3, 2'b10, 8'hF0);
    @(negedge clk);
    bus.op_flat[7:6]    = 2'b01;
    bus.mask_flat[31:24] = 8'hFF;
    waitDone("latch");
    bus.req[3] = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("latch_gnt_idle", 32'(bus.gnt), 32'h0);
    checkOutput("latch_busy_idle", 32'(bus.busy), 32'h0);
    checkOutput("latch_q_hold", 32'(bus.q), 32'hF0);

    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
